// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch-PC generator.
package fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'hBFC0_0000;
    localparam int          INSN_BYTES        = 4;
    localparam int          MAX_FETCH_WIDTH   = 8;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// I-cache request/response channel between the fetch-PC generator and the cache front end.
interface fetch_pc_gen_if #(
    parameter int CNT_W = 2
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_pc;
    logic [CNT_W-1:0] req_cnt;
    logic             rsp_valid;
    logic [CNT_W-1:0] rsp_cnt;
    logic             rsp_drop;

    modport master (
        output req_valid, req_pc, req_cnt, rsp_drop,
        input  req_ready, rsp_valid, rsp_cnt
    );

    modport slave (
        input  req_valid, req_pc, req_cnt, rsp_drop,
        output req_ready, rsp_valid, rsp_cnt
    );
endinterface

// File: rtl/fetch_pc_gen_redirect_hold.sv
// Exception/branch priority mux plus the pending-target register used while a
// squashed fetch is still in flight.
module fetch_redirect_hold (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_exception,
    input  logic [31:0] addr_exception,
    input  logic        is_branch,
    input  logic [31:0] addr_branch,
    input  logic        load_pending,
    input  logic        clear_pending,
    output logic        redir,
    output logic [31:0] target,
    output logic [31:0] resume
);
    logic [31:0] pending;

    assign redir  = is_exception | is_branch;
    assign target = is_exception ? addr_exception : addr_branch;
    // A redirect in the same cycle as the stale response beats the held one.
    assign resume = redir ? target : pending;

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else if (load_pending) begin
            pending <= target;
        end else if (clear_pending) begin
            pending <= '0;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: one outstanding I-cache fetch, redirect arbitration and
// stale-response squashing. Optional macro FETCH_PC_ALIGN_EN trims groups at aligned boundaries.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_VEC   = RESET_VEC_DEFAULT,
    parameter int          CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            full,
    input  logic            is_exception,
    input  logic [31:0]     addr_exception,
    input  logic            is_branch,
    input  logic [31:0]     addr_branch,
    fetch_pc_gen_if.master  bus,
    output logic [31:0]     pc,
    output logic            busy
);
    state_e           state, state_n;
    logic [31:0]      pc_n;
    logic [CNT_W-1:0] cnt_lat;
    logic [CNT_W-1:0] req_cnt_w;
    logic [CNT_W-1:0] eff_cnt;
    logic             cnt_load;
    logic             load_pending, clear_pending;
    logic             redir;
    logic [31:0]      target, resume;

    fetch_redirect_hold u_redirect_hold (
        .clk            (clk),
        .reset          (reset),
        .is_exception   (is_exception),
        .addr_exception (addr_exception),
        .is_branch      (is_branch),
        .addr_branch    (addr_branch),
        .load_pending   (load_pending),
        .clear_pending  (clear_pending),
        .redir          (redir),
        .target         (target),
        .resume         (resume)
    );

`ifdef FETCH_PC_ALIGN_EN
    // Word offset inside the FETCH_WIDTH*4-byte group; mask form also covers FETCH_WIDTH=1.
    localparam logic [31:0] OFF_MASK = 32'(FETCH_WIDTH - 1);
    logic [31:0] grp_off;
    assign grp_off   = (pc >> 2) & OFF_MASK;
    assign req_cnt_w = CNT_W'(FETCH_WIDTH) - CNT_W'(grp_off);
`else
    assign req_cnt_w = CNT_W'(FETCH_WIDTH);
`endif

    // The cache may return more than was asked for; never advance past the request.
    assign eff_cnt = (bus.rsp_cnt < cnt_lat) ? bus.rsp_cnt : cnt_lat;

    assign bus.req_pc  = pc;
    assign bus.req_cnt = req_cnt_w;
    assign busy        = (state != ISSUE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ISSUE;
            pc      <= RESET_VEC;
            cnt_lat <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (cnt_load) begin
                cnt_lat <= req_cnt_w;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        bus.req_valid = 1'b0;
        bus.rsp_drop  = 1'b0;
        cnt_load      = 1'b0;
        load_pending  = 1'b0;
        clear_pending = 1'b0;

        unique case (state)
            ISSUE: begin
                bus.req_valid = en & ~full & ~redir;
                if (redir) begin
                    pc_n = target;
                end else if (bus.req_valid && bus.req_ready) begin
                    cnt_load = 1'b1;
                    state_n  = WAIT;
                end
            end
            WAIT: begin
                if (bus.rsp_valid) begin
                    state_n = ISSUE;
                    if (redir) begin
                        bus.rsp_drop = 1'b1;
                        pc_n         = target;
                    end else begin
                        pc_n = pc + 32'(eff_cnt) * 32'(INSN_BYTES);
                    end
                end else if (redir) begin
                    load_pending = 1'b1;
                    state_n      = FLUSH;
                end
            end
            FLUSH: begin
                if (bus.rsp_valid) begin
                    bus.rsp_drop  = 1'b1;
                    pc_n          = resume;
                    clear_pending = 1'b1;
                    state_n       = ISSUE;
                end else if (redir) begin
                    load_pending = 1'b1;
                end
            end
            default: begin
                state_n = ISSUE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed literals.
module tb_fetch_pc_gen;
    localparam int          FW    = 2;
    localparam int          CW    = $clog2(FW + 1);
    localparam logic [31:0] RVEC  = 32'hBFC0_0000;
`ifdef FETCH_PC_ALIGN_EN
    localparam bit          ALIGN = 1'b1;
`else
    localparam bit          ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, en, full;
    logic        is_exception, is_branch;
    logic [31:0] addr_exception, addr_branch;
    logic [31:0] pc;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_pc_gen_if #(.CNT_W(CW)) bus ();

    fetch_pc_gen #(
        .FETCH_WIDTH (FW),
        .RESET_VEC   (RVEC),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .full           (full),
        .is_exception   (is_exception),
        .addr_exception (addr_exception),
        .is_branch      (is_branch),
        .addr_branch    (addr_branch),
        .bus            (bus),
        .pc             (pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: "is a fetch in flight", "will its data be thrown away", and where to go then.
    bit          m_live = 1'b0;
    bit          m_out, m_stale;
    logic [31:0] m_pc, m_pend;
    int          m_grant;

    logic        e_redir, e_req_valid, e_drop;
    logic [31:0] e_tgt;
    int          e_req_cnt, e_adv;

    always_comb begin
        e_redir     = is_exception | is_branch;
        e_tgt       = is_exception ? addr_exception : addr_branch;
        e_req_valid = !m_out && en && !full && !e_redir;
        e_drop      = m_out && bus.rsp_valid && (m_stale || e_redir);
        e_req_cnt   = ALIGN ? FW - int'((m_pc / 4) % FW) : FW;
        e_adv       = (int'(bus.rsp_cnt) < m_grant) ? int'(bus.rsp_cnt) : m_grant;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_live  <= 1'b1;
            m_out   <= 1'b0;
            m_stale <= 1'b0;
            m_pc    <= RVEC;
            m_pend  <= '0;
            m_grant <= 0;
        end else if (!m_out) begin
            if (e_redir) begin
                m_pc <= e_tgt;
            end else if (e_req_valid && bus.req_ready) begin
                m_out   <= 1'b1;
                m_grant <= e_req_cnt;
            end
        end else if (bus.rsp_valid) begin
            m_out   <= 1'b0;
            m_stale <= 1'b0;
            if (e_redir)      m_pc <= e_tgt;
            else if (m_stale) m_pc <= m_pend;
            else              m_pc <= m_pc + 32'(4 * e_adv);
        end else if (e_redir) begin
            m_stale <= 1'b1;
            m_pend  <= e_tgt;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_pc", pc, m_pc);
            check("cyc_req_pc", bus.req_pc, m_pc);
            check("cyc_req_valid", 32'(bus.req_valid), 32'(e_req_valid));
            check("cyc_busy", 32'(busy), 32'(m_out));
            if (e_req_valid) check("cyc_req_cnt", 32'(bus.req_cnt), 32'(e_req_cnt));
            if (bus.rsp_valid) check("cyc_rsp_drop", 32'(bus.rsp_drop), 32'(e_drop));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; full = 1'b0;
        is_exception = 1'b0; is_branch = 1'b0;
        addr_exception = '0; addr_branch = '0;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_cnt = '0;
        tick(); tick(); settle();
        check("rst_pc", pc, 32'hBFC0_0000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);

        // Basic fetch: request, response three cycles later, advance by 8.
        reset = 1'b0; en = 1'b1; bus.req_ready = 1'b1; settle();
        check("first_req_valid", 32'(bus.req_valid), 32'd1);
        check("first_req_pc", bus.req_pc, 32'hBFC0_0000);
        check("first_req_cnt", 32'(bus.req_cnt), 32'd2);
        tick();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_no_req", 32'(bus.req_valid), 32'd0);
        tick(); tick();
        bus.rsp_valid = 1'b1; bus.rsp_cnt = 2'd2; settle();
        check("good_rsp_no_drop", 32'(bus.rsp_drop), 32'd0);
        tick(); bus.rsp_valid = 1'b0; settle();
        check("adv_pc", pc, 32'hBFC0_0008);
        check("next_req_valid", 32'(bus.req_valid), 32'd1);

        // Branch while waiting: hold, squash the late response, resume at target.
        tick();
        is_branch = 1'b1; addr_branch = 32'h8000_0100; settle();
        tick(); is_branch = 1'b0; settle();
        check("flush_busy", 32'(busy), 32'd1);
        tick();
        bus.rsp_valid = 1'b1; bus.rsp_cnt = 2'd2; settle();
        check("flush_drop", 32'(bus.rsp_drop), 32'd1);
        tick(); bus.rsp_valid = 1'b0; settle();
        check("branch_req_pc", bus.req_pc, 32'h8000_0100);

        // Exception beats branch in the same cycle, and that cycle does not issue.
        is_exception = 1'b1; addr_exception = 32'h8000_0180;
        is_branch = 1'b1; addr_branch = 32'h8000_0200; settle();
        check("redir_no_issue", 32'(bus.req_valid), 32'd0);
        tick(); is_exception = 1'b0; is_branch = 1'b0; settle();
        check("exc_priority_pc", pc, 32'h8000_0180);

        // Blocked issue still accepts responses.
        tick(); full = 1'b1; en = 1'b0;
        tick(); bus.rsp_valid = 1'b1; bus.rsp_cnt = 2'd1;
        tick(); bus.rsp_valid = 1'b0; settle();
        check("blocked_rsp_pc", pc, 32'h8000_0184);
        check("blocked_no_req", 32'(bus.req_valid), 32'd0);
        tick(); tick(); tick();
        full = 1'b0; settle();
        check("en_low_no_req", 32'(bus.req_valid), 32'd0);
        en = 1'b1; settle();
        check("unblock_req", 32'(bus.req_valid), 32'd1);

        // Zero-count response refetches; oversize response is clamped.
        tick(); bus.rsp_valid = 1'b1; bus.rsp_cnt = 2'd0;
        tick(); bus.rsp_valid = 1'b0; settle();
        check("zero_cnt_pc", pc, 32'h8000_0184);
        check("refetch_req", 32'(bus.req_valid), 32'd1);
        tick(); bus.rsp_valid = 1'b1; bus.rsp_cnt = 2'd3;
        tick(); bus.rsp_valid = 1'b0; settle();
        check("clamp_pc", pc, ALIGN ? 32'h8000_0188 : 32'h8000_018C);

        // 32-bit wrap.
        is_branch = 1'b1; addr_branch = 32'hFFFF_FFFC; settle();
        tick(); is_branch = 1'b0; settle();
        check("wrap_start_pc", pc, 32'hFFFF_FFFC);
        tick(); bus.rsp_valid = 1'b1; bus.rsp_cnt = 2'd1;
        tick(); bus.rsp_valid = 1'b0; settle();
        check("wrap_pc", pc, 32'h0000_0000);

        // Reset mid-fetch; the orphan response lands in ISSUE and is ignored.
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; en = 1'b0;
        bus.rsp_valid = 1'b1; bus.rsp_cnt = 2'd2; settle();
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("orphan_no_drop", 32'(bus.rsp_drop), 32'd0);
        tick(); bus.rsp_valid = 1'b0; settle();
        check("orphan_pc", pc, 32'hBFC0_0000);

        // Latest redirect wins while flushing.
        en = 1'b1; settle();
        tick(); en = 1'b0;
        is_branch = 1'b1; addr_branch = 32'h0000_1000;
        tick(); addr_branch = 32'h0000_2000;
        tick(); is_branch = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_cnt = 2'd2; settle();
        check("latest_drop", 32'(bus.rsp_drop), 32'd1);
        tick(); bus.rsp_valid = 1'b0; settle();
        check("latest_pc", pc, 32'h0000_2000);

        // Response and redirect together in WAIT.
        en = 1'b1; settle();
        tick(); en = 1'b0;
        bus.rsp_valid = 1'b1; is_exception = 1'b1; addr_exception = 32'h0000_3000; settle();
        check("wait_redir_drop", 32'(bus.rsp_drop), 32'd1);
        tick(); bus.rsp_valid = 1'b0; is_exception = 1'b0; settle();
        check("wait_redir_pc", pc, 32'h0000_3000);
        check("wait_redir_busy", 32'(busy), 32'd0);

`ifdef FETCH_PC_ALIGN_EN
        is_branch = 1'b1; addr_branch = 32'h8000_0004; settle();
        tick(); is_branch = 1'b0; en = 1'b1; settle();
        check("align_req_cnt", 32'(bus.req_cnt), 32'd1);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
